// File: rtl/bilin_fetch_ctrl.sv
// Bilinear fetch sequencer: one coordinate request becomes four clamped neighbour
// reads, absorbs the 1-cycle memory latency and serialises writebacks onto port 0.
module bilin_fetch_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [ADDR_W-1:0]  cfg_src_base,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_p00,
  output logic [7:0]         out_p01,
  output logic [7:0]         out_p10,
  output logic [7:0]         out_p11,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [7:0]         wb_data,
  output logic [ADDR_W-1:0]  raddr0,
  output logic [ADDR_W-1:0]  raddr1,
  output logic [ADDR_W-1:0]  raddr2,
  output logic [ADDR_W-1:0]  raddr3,
  input  logic [7:0]         rdata0,
  input  logic [7:0]         rdata1,
  input  logic [7:0]         rdata2,
  input  logic [7:0]         rdata3,
  output logic [ADDR_W-1:0]  waddr0,
  output logic [7:0]         wdata0,
  output logic               we0,
  output logic [ADDR_W-1:0]  waddr1,
  output logic [7:0]         wdata1,
  output logic               we1,
  output logic [ADDR_W-1:0]  waddr2,
  output logic [7:0]         wdata2,
  output logic               we2,
  output logic [ADDR_W-1:0]  waddr3,
  output logic [7:0]         wdata3,
  output logic               we3,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  localparam int PW = 2 * COORD_W;
  localparam int SW = ((ADDR_W > PW) ? ADDR_W : PW) + 1;

  state_t state, state_nxt;
  logic   accept;
  logic [COORD_W-1:0] wm1, hm1, x0, x1, y0, y1;

  // Full-width sum, then truncation: addresses wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0]  base,
                                                input logic [COORD_W-1:0] w,
                                                input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    prod = {{COORD_W{1'b0}}, y} * {{COORD_W{1'b0}}, w};
    sum  = SW'(base) + SW'(prod) + SW'(x);
    return sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    wm1 = cfg_width - COORD_W'(1);
    hm1 = cfg_height - COORD_W'(1);
    x0  = (req_x > wm1) ? wm1 : req_x;
    y0  = (req_y > hm1) ? hm1 : req_y;
    x1  = (x0 < wm1) ? x0 + COORD_W'(1) : wm1;
    y1  = (y0 < hm1) ? y0 + COORD_W'(1) : hm1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A fetch never starts while a write is in flight, so reads see every issued write.
  always_comb begin
    req_ready = (state == IDLE) && !we0;
    out_valid = (state == OUT);
    wb_ready  = 1'b1;
    accept    = req_valid && req_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr0   <= '0;
      raddr1   <= '0;
      raddr2   <= '0;
      raddr3   <= '0;
      out_p00  <= '0;
      out_p01  <= '0;
      out_p10  <= '0;
      out_p11  <= '0;
      rd_count <= '0;
    end else begin
      if (accept) begin
        raddr0 <= addr_of(cfg_src_base, cfg_width, x0, y0);
        raddr1 <= addr_of(cfg_src_base, cfg_width, x1, y0);
        raddr2 <= addr_of(cfg_src_base, cfg_width, x0, y1);
        raddr3 <= addr_of(cfg_src_base, cfg_width, x1, y1);
      end
      if (state == CAP) begin
        out_p00 <= rdata0;
        out_p01 <= rdata1;
        out_p10 <= rdata2;
        out_p11 <= rdata3;
      end
      if (state == OUT && out_ready) rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr0   <= '0;
      wdata0   <= '0;
      we0      <= 1'b0;
      wr_count <= '0;
    end else begin
      we0 <= wb_valid;
      if (wb_valid) begin
        waddr0   <= wb_addr;
        wdata0   <= wb_data;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign waddr1 = '0;
  assign waddr2 = '0;
  assign waddr3 = '0;
  assign wdata1 = '0;
  assign wdata2 = '0;
  assign wdata3 = '0;
  assign we1    = 1'b0;
  assign we2    = 1'b0;
  assign we3    = 1'b0;

endmodule

// File: tb/tb_bilin_fetch_ctrl.sv
// Bench for bilin_fetch_ctrl: directed vector table, hazard/backpressure/reset
// sequences, then random fetches and writebacks checked against a coordinate model.
module tb_bilin_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_width = 8'd1, cfg_height = 8'd1;
  logic [11:0] cfg_src_base = '0;
  logic        req_valid = 1'b0, req_ready;
  logic [7:0]  req_x = '0, req_y = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  out_p00, out_p01, out_p10, out_p11;
  logic        wb_valid = 1'b0, wb_ready;
  logic [11:0] wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic [11:0] raddr0, raddr1, raddr2, raddr3;
  logic [7:0]  rdata0, rdata1, rdata2, rdata3;
  logic [11:0] waddr0, waddr1, waddr2, waddr3;
  logic [7:0]  wdata0, wdata1, wdata2, wdata3;
  logic        we0, we1, we2, we3;
  logic [15:0] rd_count, wr_count;

  bilin_fetch_ctrl #(.ADDR_W(12), .COORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_src_base(cfg_src_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p00(out_p00), .out_p01(out_p01), .out_p10(out_p10), .out_p11(out_p11),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .waddr0(waddr0), .wdata0(wdata0), .we0(we0),
    .waddr1(waddr1), .wdata1(wdata1), .we1(we1),
    .waddr2(waddr2), .wdata2(wdata2), .we2(we2),
    .waddr3(waddr3), .wdata3(wdata3), .we3(we3),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Memory with 1-cycle read latency; same-edge read returns the old word.
  logic [7:0] mem [4096];
  logic       load_mem = 1'b0;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
    end else if (we0) begin
      mem[waddr0] <= wdata0;
    end
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
    rdata2 <= mem[raddr2];
    rdata3 <= mem[raddr3];
  end

  logic [7:0] ref_mem [4096];
  int cur_w, cur_h, cur_base;
  int rd_exp, wr_exp;
  int applied = 0;
  int miscompares = 0;

  typedef struct {
    int w, h, base, x, y;
    int a0, a1, a2, a3;
    int p0, p1, p2, p3;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int base);
    cur_w = w; cur_h = h; cur_base = base;
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_src_base = 12'(base);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: clamp, neighbour, linear address modulo memory depth.
  function automatic void model(input int x, input int y,
                                output logic [47:0] ea, output logic [31:0] ep);
    int xa, xb, ya, yb;
    int a [4];
    xa = min2(x, cur_w - 1);
    ya = min2(y, cur_h - 1);
    xb = min2(xa + 1, cur_w - 1);
    yb = min2(ya + 1, cur_h - 1);
    a[0] = (cur_base + ya * cur_w + xa) % 4096;
    a[1] = (cur_base + ya * cur_w + xb) % 4096;
    a[2] = (cur_base + yb * cur_w + xa) % 4096;
    a[3] = (cur_base + yb * cur_w + xb) % 4096;
    ea = {12'(a[3]), 12'(a[2]), 12'(a[1]), 12'(a[0])};
    ep = {ref_mem[a[3]], ref_mem[a[2]], ref_mem[a[1]], ref_mem[a[0]]};
  endfunction

  task automatic fetch(input int x, input int y, input int hold,
                       input logic [47:0] ea, input logic [31:0] ep, output int waited);
    int n = 0;
    req_x = 8'(x); req_y = 8'(y); req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    waited = n;
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ov_after_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("ov_after_rd", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("ov_after_cap", 32'(out_valid), 32'd1);
    chk("raddr0", 32'(raddr0), 32'(ea[11:0]));
    chk("raddr1", 32'(raddr1), 32'(ea[23:12]));
    chk("raddr2", 32'(raddr2), 32'(ea[35:24]));
    chk("raddr3", 32'(raddr3), 32'(ea[47:36]));
    chk("p00", 32'(out_p00), 32'(ep[7:0]));
    chk("p01", 32'(out_p01), 32'(ep[15:8]));
    chk("p10", 32'(out_p10), 32'(ep[23:16]));
    chk("p11", 32'(out_p11), 32'(ep[31:24]));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_pix", {out_p11, out_p10, out_p01, out_p00}, ep);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rd_exp++;
    chk("ov_after_release", 32'(out_valid), 32'd0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("rd_count", 32'(rd_count), 32'(rd_exp & 16'hFFFF));
  endtask

  task automatic wb(input int addr, input int data);
    wb_addr = 12'(addr); wb_data = 8'(data); wb_valid = 1'b1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    ref_mem[addr] = 8'(data);
    wr_exp++;
    chk("we0", 32'(we0), 32'd1);
    chk("waddr0", 32'(waddr0), 32'(addr));
    chk("wdata0", 32'(wdata0), 32'(data));
    chk("wr_count", 32'(wr_count), 32'(wr_exp & 16'hFFFF));
    chk("req_ready_during_we", 32'(req_ready), 32'd0);
  endtask

  initial begin
    vec_t tbl [6];
    logic [47:0] ea;
    logic [31:0] ep;
    int waited;

    tbl[0] = '{64, 64, 0,     10,  5, 330,  331,  394,  395,  'h4A, 'h4B, 'h8A, 'h8B};
    tbl[1] = '{64, 64, 0,     63, 63, 4095, 4095, 4095, 4095, 'hFF, 'hFF, 'hFF, 'hFF};
    tbl[2] = '{64, 64, 0,    200, 10, 703,  703,  767,  767,  'hBF, 'hBF, 'hFF, 'hFF};
    tbl[3] = '{32, 4,  'hFF0, 20,  0, 4,    5,    36,   37,   'h04, 'h05, 'h24, 'h25};
    tbl[4] = '{1,  1,  'h100,  5,  7, 256,  256,  256,  256,  'h00, 'h00, 'h00, 'h00};
    tbl[5] = '{3,  2,  0,      1,  0, 1,    2,    4,    5,    'h01, 'h02, 'h04, 'h05};

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i);
    rd_exp = 0; wr_exp = 0;
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_raddr0", 32'(raddr0), 32'd0);
    chk("rst_we0", 32'(we0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("rst_counts", {rd_count, wr_count}, 32'd0);
    chk("tied_we123", {29'd0, we1, we2, we3}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i].w, tbl[i].h, tbl[i].base);
      ea = {12'(tbl[i].a3), 12'(tbl[i].a2), 12'(tbl[i].a1), 12'(tbl[i].a0)};
      ep = {8'(tbl[i].p3), 8'(tbl[i].p2), 8'(tbl[i].p1), 8'(tbl[i].p0)};
      fetch(tbl[i].x, tbl[i].y, (i == 0) ? 5 : 0, ea, ep, waited);
    end

    // Writeback then fetch of a neighbour of the written address: deferred one cycle.
    set_cfg(64, 64, 0);
    wb(331, 'h5A);
    fetch(10, 5, 0, {12'd395, 12'd394, 12'd331, 12'd330}, {8'h8B, 8'h8A, 8'h5A, 8'h4A}, waited);
    chk("hazard_defer_cycles", 32'(waited), 32'd1);
    chk("hazard_wr_count", 32'(wr_count), 32'd1);

    // Reset while in CAP drops the fetch.
    req_x = 8'd10; req_y = 8'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_raddr", {raddr0 | raddr1 | raddr2 | raddr3}, 32'd0);
    chk("midrst_we", {28'd0, we0, we1, we2, we3}, 32'd0);
    chk("midrst_counts", {rd_count, wr_count}, 32'd0);
    chk("midrst_pix", {out_p11, out_p10, out_p01, out_p00}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_held_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    rd_exp = 0; wr_exp = 0;
    @(posedge clk); #1;
    model(10, 5, ea, ep);
    fetch(10, 5, 0, ea, ep, waited);

    for (int it = 0; it < 60; it++) begin
      int nwb;
      set_cfg($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(0, 4095));
      nwb = $urandom_range(0, 3);
      for (int j = 0; j < nwb; j++) wb($urandom_range(0, 4095), $urandom_range(0, 255));
      begin
        int rx, ry;
        rx = $urandom_range(0, 255);
        ry = $urandom_range(0, 255);
        model(rx, ry, ea, ep);
        fetch(rx, ry, $urandom_range(0, 3), ea, ep, waited);
      end
    end
    chk("final_wr_count", 32'(wr_count), 32'(wr_exp & 16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
